// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl: loop sequencer for a lane-parallel convolution engine.
// Walks y, x, output-lane group, input channel, ky, kx. Each kernel tap
// costs one FETCH_A, one FETCH_B and one MAC cycle. After the last tap of
// a lane group the block waits in OUT for the result handshake.
// Optional build macro CONV_LOOP_CTRL_PERF_EN adds the busy-cycle and
// stall-cycle counters. Without it, perf_cycles and perf_stalls are tied to 0.
module conv_loop_ctrl #(
   parameter int FEATURE_MAP_WIDTH  = 1024,
   parameter int FEATURE_MAP_HEIGHT = 1024,
   parameter int INPUT_NB_CHANNELS  = 64,
   parameter int OUTPUT_NB_CHANNELS = 64,
   parameter int MAC_LANES          = 4,
   parameter int CNT_W              = 32
) (
   input  logic             clk,
   input  logic             arst_n_in,
   input  logic             start,
   input  logic [1:0]       conv_kernel_mode,
   input  logic [1:0]       conv_stride_mode,
   output logic             busy,
   output logic             done,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic             b_valid,
   output logic             b_ready,
   output logic             write_a,
   output logic             write_b,
   output logic             mac_valid,
   output logic             mac_clear,
   output logic             mac_accumulate,
   output logic [2:0]       kx,
   output logic [2:0]       ky,
   output logic [(INPUT_NB_CHANNELS > 1 ? $clog2(INPUT_NB_CHANNELS) : 1)-1:0] ch_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_x,
   output logic [CNT_W-1:0] out_y,
   output logic [CNT_W-1:0] out_ch,
   output logic [CNT_W-1:0] perf_cycles,
   output logic [CNT_W-1:0] perf_stalls
);

   localparam int CIW = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;
   localparam logic [CIW-1:0]   CI_MAX = CIW'(INPUT_NB_CHANNELS - 1);
   localparam logic [CNT_W:0]   MAP_W  = (CNT_W+1)'(FEATURE_MAP_WIDTH);
   localparam logic [CNT_W:0]   MAP_H  = (CNT_W+1)'(FEATURE_MAP_HEIGHT);
   localparam logic [CNT_W:0]   OCH_N  = (CNT_W+1)'(OUTPUT_NB_CHANNELS);
   localparam logic [CNT_W:0]   LANES  = (CNT_W+1)'(MAC_LANES);

   typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, MAC, OUT} state_t;

   state_t           state_reg, state_next;
   logic [1:0]       kmode_reg, smode_reg;
   logic [2:0]       kx_reg, ky_reg;
   logic [CIW-1:0]   ci_reg;
   logic [CNT_W-1:0] x_reg, y_reg, och_reg;
   logic             busy_reg, a_ready_reg, b_ready_reg, mac_valid_reg;
   logic             mac_clear_reg, mac_acc_reg, out_valid_reg, done_reg;

   logic [2:0]       k_max;
   logic [CNT_W:0]   s_val;
   logic             last_kx, last_ky, last_ci, last_tap, first_tap;
   logic             last_x, last_y, last_och, last_out;

   // Loop bounds derived from the modes latched for this run
   always_comb begin
      s_val      = '0;
      s_val[3:0] = 4'd1 << smode_reg;
      k_max      = {kmode_reg, 1'b0};
      last_kx    = (kx_reg == k_max);
      last_ky    = (ky_reg == k_max);
      last_ci    = (ci_reg == CI_MAX);
      last_tap   = last_kx && last_ky && last_ci;
      first_tap  = (kx_reg == 3'd0) && (ky_reg == 3'd0) && (ci_reg == '0);
      last_x     = ({1'b0, x_reg} + s_val) >= MAP_W;
      last_y     = ({1'b0, y_reg} + s_val) >= MAP_H;
      last_och   = ({1'b0, och_reg} + LANES) >= OCH_N;
      last_out   = last_och && last_x && last_y;
   end

   // Next-state decode for the tap/result sequencer
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start)     state_next = FETCH_A;
         FETCH_A: if (a_valid)   state_next = FETCH_B;
         FETCH_B: if (b_valid)   state_next = MAC;
         MAC:                    state_next = last_tap ? OUT : FETCH_A;
         OUT:     if (out_ready) state_next = last_out ? IDLE : FETCH_A;
         default:                state_next = IDLE;
      endcase
   end

   // State register with outputs registered from the next state
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_reg     <= IDLE;
         busy_reg      <= 1'b0;
         a_ready_reg   <= 1'b0;
         b_ready_reg   <= 1'b0;
         mac_valid_reg <= 1'b0;
         mac_clear_reg <= 1'b0;
         mac_acc_reg   <= 1'b0;
         out_valid_reg <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         busy_reg      <= (state_next != IDLE);
         a_ready_reg   <= (state_next == FETCH_A);
         b_ready_reg   <= (state_next == FETCH_B);
         mac_valid_reg <= (state_next == MAC);
         // MAC is entered only from FETCH_B, where the tap counters are settled
         mac_clear_reg <= (state_next == MAC) && first_tap;
         mac_acc_reg   <= (state_next == MAC) && !first_tap;
         out_valid_reg <= (state_next == OUT);
         done_reg      <= (state_reg == OUT) && out_ready && last_out;
      end
   end

   // Mode latch and nested loop counters; all wrap to 0 after the last output
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         kmode_reg <= '0;
         smode_reg <= '0;
         kx_reg    <= '0;
         ky_reg    <= '0;
         ci_reg    <= '0;
         x_reg     <= '0;
         y_reg     <= '0;
         och_reg   <= '0;
      end else if (state_reg == IDLE) begin
         if (start) begin
            kmode_reg <= conv_kernel_mode;
            smode_reg <= conv_stride_mode;
            kx_reg    <= '0;
            ky_reg    <= '0;
            ci_reg    <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            och_reg   <= '0;
         end
      end else if (state_reg == MAC) begin
         kx_reg <= last_kx ? 3'd0 : kx_reg + 3'd1;
         if (last_kx) begin
            ky_reg <= last_ky ? 3'd0 : ky_reg + 3'd1;
            if (last_ky) ci_reg <= last_ci ? '0 : ci_reg + CIW'(1);
         end
      end else if (state_reg == OUT && out_ready) begin
         och_reg <= last_och ? '0 : och_reg + CNT_W'(MAC_LANES);
         if (last_och) begin
            x_reg <= last_x ? '0 : x_reg + s_val[CNT_W-1:0];
            if (last_x) y_reg <= last_y ? '0 : y_reg + s_val[CNT_W-1:0];
         end
      end
   end

   assign busy           = busy_reg;
   assign done           = done_reg;
   assign a_ready        = a_ready_reg;
   assign b_ready        = b_ready_reg;
   assign write_a        = a_ready_reg && a_valid;
   assign write_b        = b_ready_reg && b_valid;
   assign mac_valid      = mac_valid_reg;
   assign mac_clear      = mac_clear_reg;
   assign mac_accumulate = mac_acc_reg;
   assign kx             = kx_reg;
   assign ky             = ky_reg;
   assign ch_in          = ci_reg;
   assign out_valid      = out_valid_reg;
   assign out_x          = x_reg;
   assign out_y          = y_reg;
   assign out_ch         = och_reg;

`ifdef CONV_LOOP_CTRL_PERF_EN
   logic [CNT_W-1:0] cyc_reg, stall_reg;
   logic             stall_now;

   assign stall_now = ((state_reg == FETCH_A) && !a_valid) ||
                      ((state_reg == FETCH_B) && !b_valid) ||
                      ((state_reg == OUT)     && !out_ready);

   // Saturating busy/stall counters, cleared when a run is accepted
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         cyc_reg   <= '0;
         stall_reg <= '0;
      end else if (state_reg == IDLE) begin
         if (start) begin
            cyc_reg   <= '0;
            stall_reg <= '0;
         end
      end else begin
         if (!(&cyc_reg))              cyc_reg   <= cyc_reg + CNT_W'(1);
         if (stall_now && !(&stall_reg)) stall_reg <= stall_reg + CNT_W'(1);
      end
   end

   assign perf_cycles = cyc_reg;
   assign perf_stalls = stall_reg;
`else
   assign perf_cycles = '0;
   assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// tb_conv_loop_ctrl: directed bench for conv_loop_ctrl on a 4x4 map,
// 2 input channels, 4 output channels, 2 lanes. Perf expectations follow
// whether CONV_LOOP_CTRL_PERF_EN is defined for the build.
module tb_conv_loop_ctrl;

   localparam int CNT_W = 32;
`ifdef CONV_LOOP_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             arst_n_in = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       conv_kernel_mode = 2'd0;
   logic [1:0]       conv_stride_mode = 2'd0;
   logic             a_valid = 1'b1;
   logic             b_valid = 1'b1;
   logic             out_ready = 1'b1;
   logic             busy, done, a_ready, b_ready, write_a, write_b;
   logic             mac_valid, mac_clear, mac_accumulate, out_valid;
   logic [2:0]       kx, ky;
   logic [0:0]       ch_in;
   logic [CNT_W-1:0] out_x, out_y, out_ch, perf_cycles, perf_stalls;

   conv_loop_ctrl #(
      .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4), .INPUT_NB_CHANNELS(2),
      .OUTPUT_NB_CHANNELS(4), .MAC_LANES(2), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .arst_n_in(arst_n_in), .start(start),
      .conv_kernel_mode(conv_kernel_mode), .conv_stride_mode(conv_stride_mode),
      .busy(busy), .done(done), .a_valid(a_valid), .a_ready(a_ready),
      .b_valid(b_valid), .b_ready(b_ready), .write_a(write_a), .write_b(write_b),
      .mac_valid(mac_valid), .mac_clear(mac_clear), .mac_accumulate(mac_accumulate),
      .kx(kx), .ky(ky), .ch_in(ch_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
      .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Run monitor: beat counters, first/last result coordinate, rule violations
   logic        mon_clr = 1'b0;
   logic [1:0]  run_k = 2'd0;
   int          mac_cnt, clr_cnt, out_cnt, busy_cnt;
   int          rule_err = 0;
   logic [95:0] first_beat, last_beat;

   always @(negedge clk) begin
      if (mon_clr) begin
         mac_cnt    <= 0;
         clr_cnt    <= 0;
         out_cnt    <= 0;
         busy_cnt   <= 0;
         first_beat <= '1;
         last_beat  <= '1;
      end else begin
         if (busy) busy_cnt <= busy_cnt + 1;
         if (mac_valid) begin
            mac_cnt <= mac_cnt + 1;
            if (mac_clear) clr_cnt <= clr_cnt + 1;
         end
         if (out_valid && out_ready) begin
            if (out_cnt == 0) first_beat <= {out_x, out_y, out_ch};
            last_beat <= {out_x, out_y, out_ch};
            out_cnt   <= out_cnt + 1;
         end
      end
      if (mac_accumulate !== (mac_valid && !mac_clear) ||
          write_a !== (a_ready && a_valid) || write_b !== (b_ready && b_valid) ||
          (!mac_valid && (mac_clear || mac_accumulate)) ||
          (mac_valid && run_k == 2'd0 && (kx != 3'd0 || ky != 3'd0)))
         rule_err <= rule_err + 1;
   end

   // Launch a run, optionally poke start/modes mid-run, wait for done
   task automatic run(input logic [1:0] km, input logic [1:0] sm, input int poke, input int budget);
      int timeout;
      @(posedge clk); #1;
      mon_clr = 1'b1;
      run_k = km;
      start = 1'b1;
      conv_kernel_mode = km;
      conv_stride_mode = sm;
      @(posedge clk); #1;
      mon_clr = 1'b0;
      start = 1'b0;
      conv_kernel_mode = ~km;
      conv_stride_mode = ~sm;
      if (poke > 0) begin
         repeat (poke) @(posedge clk);
         #1;
         start = 1'b1;
         conv_kernel_mode = 2'd3;
         conv_stride_mode = 2'd3;
         @(posedge clk); #1;
         start = 1'b0;
      end
      timeout = 1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            timeout = 0;
            break;
         end
      end
      check("done_timeout", timeout, 0);
      @(negedge clk);
      check("done_pulse", {busy, done}, 0);
   endtask

   logic [95:0] cap;
   int          got, n;

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctl", {busy, done, a_ready, b_ready, write_a, write_b, mac_valid,
                        mac_clear, mac_accumulate, out_valid, kx, ky, ch_in}, 0);
      check("rst_coord", {out_x, out_y, out_ch}, 0);
      check("rst_perf", {perf_cycles, perf_stalls}, 0);
      arst_n_in = 1'b1;

      // K=1, S=1, no back-pressure
      run(2'd0, 2'd0, 0, 2000);
      check("k1_mac", mac_cnt, 64);
      check("k1_out", out_cnt, 32);
      check("k1_first", first_beat, 96'd0);
      check("k1_last", last_beat, {32'd3, 32'd3, 32'd2});
      check("k1_busy", busy_cnt, 224);
      check("k1_clear", clr_cnt, 32);
      check("k1_perf_cyc", perf_cycles, PERF ? 224 : 0);
      check("k1_perf_stl", perf_stalls, 0);

      // K=3, S=2
      run(2'd1, 2'd1, 0, 2000);
      check("k3_mac", mac_cnt, 144);
      check("k3_out", out_cnt, 8);
      check("k3_clear", clr_cnt, 8);
      check("k3_last", last_beat, {32'd2, 32'd2, 32'd2});
      check("k3_busy", busy_cnt, 144 * 3 + 8);

      // out_ready low for 5 cycles of the first OUT
      out_ready = 1'b0;
      fork
         run(2'd0, 2'd0, 0, 2000);
         begin
            got = 0;
            for (int i = 0; i < 200; i++) begin
               @(negedge clk);
               if (out_valid) begin
                  got = 1;
                  break;
               end
            end
            check("stall_reach", got, 1);
            cap = {out_x, out_y, out_ch};
            check("stall_first", cap, 96'd0);
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               check("stall_hold", {out_valid, a_ready, b_ready, out_x, out_y, out_ch}, {3'b100, cap});
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      check("stall_out", out_cnt, 32);
      check("stall_busy", busy_cnt, 229);
      check("stall_perf_stl", perf_stalls, PERF ? 5 : 0);
      check("stall_perf_cyc", perf_cycles, PERF ? 229 : 0);

      // a_valid low for 3 cycles of every FETCH_A
      begin
         bit drv_en;
         int wait_cnt;
         drv_en = 1'b1;
         wait_cnt = 0;
         fork
            begin
               run(2'd0, 2'd0, 0, 4000);
               drv_en = 1'b0;
            end
            while (drv_en) begin
               @(posedge clk); #1;
               if (a_ready) begin
                  wait_cnt++;
                  a_valid = (wait_cnt == 4);
               end else begin
                  wait_cnt = 0;
                  a_valid = 1'b0;
               end
            end
         join
         a_valid = 1'b1;
      end
      check("av_mac", mac_cnt, 64);
      check("av_busy", busy_cnt, 224 + 192);
      check("av_perf_stl", perf_stalls, PERF ? 192 : 0);

      // Asynchronous reset in the middle of the 10th MAC beat
      @(posedge clk); #1;
      start = 1'b1;
      conv_kernel_mode = 2'd0;
      conv_stride_mode = 2'd0;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (mac_valid) n++;
         if (n == 10) break;
      end
      check("rst_reach", n, 10);
      arst_n_in = 1'b0;
      #1;
      check("arst_ctl", {busy, done, a_ready, b_ready, write_a, write_b, mac_valid,
                         mac_clear, mac_accumulate, out_valid, kx, ky, ch_in}, 0);
      check("arst_coord", {out_x, out_y, out_ch}, 0);
      check("arst_perf", {perf_cycles, perf_stalls}, 0);
      @(posedge clk); #1;
      arst_n_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("arst_idle", {busy, a_ready, mac_valid}, 0);

      // Restart with a start pulse and mode change injected mid-run
      run(2'd0, 2'd0, 20, 2000);
      check("re_mac", mac_cnt, 64);
      check("re_out", out_cnt, 32);
      check("re_first", first_beat, 96'd0);
      check("re_busy", busy_cnt, 224);
      check("re_perf_cyc", perf_cycles, PERF ? 224 : 0);

      check("rules", rule_err, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_loop_ctrl.md
CONV_LOOP_CTRL -- requirements
Module: conv_loop_ctrl

Interface
REQ-001 SHALL have parameter FEATURE_MAP_WIDTH, default 1024: input map width in pixels.
REQ-002 SHALL have parameter FEATURE_MAP_HEIGHT, default 1024: input map height in pixels.
REQ-003 SHALL have parameter INPUT_NB_CHANNELS, default 64: input channel count.
REQ-004 SHALL have parameter OUTPUT_NB_CHANNELS, default 64: output channel count, a multiple of MAC_LANES.
REQ-005 SHALL have parameter MAC_LANES, default 4: output channels computed in parallel per MAC beat.
REQ-006 SHALL have parameter CNT_W, default 32: width of the coordinate outputs and performance counters.
REQ-007 clk  in  1  clock; every flop is rising-edge.
REQ-008 arst_n_in  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-010 conv_kernel_mode  in  2  selects kernel size K = 2*mode+1 (1, 3, 5 or 7).
REQ-011 conv_stride_mode  in  2  selects stride S = 1<<mode (1, 2, 4 or 8).
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse when a run completes.
REQ-014 a_valid, a_ready  in/out  1  feature-data handshake.
REQ-015 b_valid, b_ready  in/out  1  weight handshake.
REQ-016 write_a, write_b  out  1  capture strobes for the operand registers.
REQ-017 mac_valid  out  1  the MAC lanes compute this cycle.
REQ-018 mac_clear  out  1  with mac_valid: the lanes start from 0.
REQ-019 mac_accumulate  out  1  with mac_valid: the lanes add to their current sum.
REQ-020 kx, ky  out  3 each  current kernel tap.
REQ-021 ch_in  out  $clog2(INPUT_NB_CHANNELS)  current input channel.
REQ-022 out_valid, out_ready  out/in  1  result handshake.
REQ-023 out_x, out_y, out_ch  out  CNT_W each  result coordinate; out_ch is the first channel of the lane group.
REQ-024 perf_cycles, perf_stalls  out  CNT_W each  performance counters.

Function
REQ-025 SHALL latch K and S on the cycle start is accepted, and hold them for the whole run.
REQ-026 Loop order, outer to inner, SHALL be: y, x, lane group (OUTPUT_NB_CHANNELS/MAC_LANES groups), ch_in, ky, kx.
REQ-027 x and y SHALL take the values 0, S, 2S, …; the last value is the first one that is >= dim-S.
REQ-028 States SHALL be IDLE, FETCH_A, FETCH_B, MAC, OUT.
- IDLE goes to FETCH_A on start.
- FETCH_A raises a_ready and goes to FETCH_B on a_valid.
- FETCH_B raises b_ready and goes to MAC on b_valid.
- MAC goes to OUT on the last tap of the last ch_in; otherwise it goes to FETCH_A.
- OUT goes, on out_ready, to IDLE after the last output, otherwise to FETCH_A.
REQ-029 write_a SHALL equal a_ready&&a_valid, and write_b SHALL equal b_ready&&b_valid.
REQ-030 mac_valid SHALL be 1 only in MAC.
REQ-031 In MAC, mac_clear SHALL be 1 exactly when ch_in==0, ky==0 and kx==0, and mac_accumulate SHALL equal !mac_clear.
REQ-032 The counters SHALL advance only on MAC or on an accepted OUT beat.
REQ-033 With zero-latency valids, each tap SHALL take exactly 3 cycles.
REQ-034 out_valid SHALL be 1 only in OUT.
REQ-035 While out_valid is 1 and out_ready is 0, out_x, out_y and out_ch SHALL hold stable, and a_ready and b_ready SHALL be 0.
REQ-036 done SHALL pulse on the OUT→IDLE transition.
REQ-037 start SHALL be ignored while busy.
REQ-038 A mode change while busy SHALL have no effect on the run.
REQ-039 For K=1, kx and ky SHALL stay 0.
REQ-040 If S exceeds a map dimension, that dimension SHALL produce a single position, 0.

Reset
REQ-041 Assertion of arst_n_in SHALL immediately force, from any state including mid-run:
- state IDLE;
- all counters and latched modes to 0;
- all outputs to 0.
REQ-042 After deassertion, the block SHALL wait for a new start.

Configuration
REQ-043 With macro CONV_LOOP_CTRL_PERF_EN defined:
- perf_cycles SHALL count busy cycles;
- perf_stalls SHALL count cycles in FETCH_A with !a_valid, in FETCH_B with !b_valid, and in OUT with !out_ready;
- both counters SHALL clear when start is accepted and saturate at all-ones.
REQ-044 Without CONV_LOOP_CTRL_PERF_EN, perf_cycles and perf_stalls SHALL be constant 0 and no counter flops shall exist.

Verification
REQ-045 Base config for all scenarios: W=H=4, CH_IN=2, CH_OUT=4, LANES=2.
- K=1, S=1, valids and out_ready tied to 1 → 64 MAC beats, 32 OUT beats, first beat (0,0,0), last beat (3,3,2), done after 224 busy cycles.
- K=3, S=2 → 144 MAC beats and 8 OUT beats; mac_clear high on 8 of those MAC beats.
- out_ready held low 5 cycles in the first OUT → out_valid and its fields hold, a_ready=0, perf_stalls=5.
- a_valid low 3 cycles in each FETCH_A (K=1, S=1) → MAC count unchanged, busy cycles extended by 192.
- reset pulsed in the middle of the 10th MAC → IDLE next cycle, busy=0, all outputs 0; start during busy is ignored; a restarted run begins at (0,0,0).
- build without CONV_LOOP_CTRL_PERF_EN → perf_cycles and perf_stalls stay 0 through the K=1 run above.
